counter_sched: RTL

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched.sv | 100 ++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// Two-requester burst scheduler driving a shared up-counter: clear, count to the latched length, pulse done.
// Define COUNTER_SCHED_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module counter_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] cnt_data,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             win_q, win_d;
  logic             pick;
  logic [1:0]       win_oh;

`ifdef COUNTER_SCHED_RR_EN
  // pref_q names the requester that wins the next conflict.
  logic pref_q, pref_d;

  always_comb begin
    pick = (req == 2'b11) ? pref_q : req[1];
  end

  always_comb begin
    pref_d = pref_q;
    if (state_q == StIdle && req != 2'b00) begin
      pref_d = ~pick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pref_q <= 1'b0;
    end else begin
      pref_q <= pref_d;
    end
  end
`else
  always_comb begin
    pick = ~req[0];
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          win_d   = pick;
          len_d   = pick ? len1 : len0;
          state_d = StClear;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        if (cnt_data == len_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    win_oh     = win_q ? 2'b10 : 2'b01;
    busy       = (state_q != StIdle);
    gnt        = busy ? win_oh : 2'b00;
    done       = (state_q == StDone) ? win_oh : 2'b00;
    cnt_reset  = reset || (state_q == StClear);
    // Combinational stop so the counter never passes len_q.
    cnt_enable = !reset && (state_q == StRun) && (cnt_data != len_q);
  end

endmodule
